fxp_mult: RTL and testbench

- Pipelined signed fixed-point multiplier for QLEN-bit two's-complement words with FRAC_SIZE fractional bits (default Q4.12).
- Used as the scalar multiply primitive in the circular-convolution datapath.
- Takes two operands plus a valid strobe. Produces a rounded, saturated product in the same Q format, with a valid strobe and an overflow flag.

---
 rtl/fxp_mult.sv | 73 +++++++
 tb/tb_fxp_mult.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fxp_mult.sv
// Two-stage signed fixed-point multiplier: full product, round half toward +inf, saturate to QLEN bits.
// Latency 2 cycles, one sample per cycle, no backpressure (no ready).
module fxp_mult #(
  parameter int QLEN      = 16,
  parameter int FRAC_SIZE = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [QLEN-1:0] a,
  input  logic [QLEN-1:0] b,
  output logic [QLEN-1:0] res,
  output logic            out_valid,
  output logic            ovf
);

  localparam int PW = 2 * QLEN;

  // One extra bit above the product keeps the rounding add from wrapping.
  localparam logic signed [PW:0] C_HALF = (PW + 1)'(1) << (FRAC_SIZE - 1);
  localparam logic signed [PW:0] C_MAX  = {{(QLEN + 2){1'b0}}, {(QLEN - 1){1'b1}}};
  localparam logic signed [PW:0] C_MIN  = {{(QLEN + 2){1'b1}}, {(QLEN - 1){1'b0}}};

  logic signed [PW-1:0] w_a_ext;
  logic signed [PW-1:0] w_b_ext;
  logic signed [PW-1:0] w_prod;
  logic signed [PW:0]   w_sum;
  logic signed [PW:0]   w_rnd;
  logic [QLEN-1:0]      w_res;
  logic                 w_ovf;

  logic signed [PW-1:0] r_prod;
  logic                 r_vld1;

  assign w_a_ext = {{QLEN{a[QLEN-1]}}, a};
  assign w_b_ext = {{QLEN{b[QLEN-1]}}, b};
  assign w_prod  = w_a_ext * w_b_ext;

  assign w_sum = {r_prod[PW-1], r_prod} + C_HALF;
  assign w_rnd = w_sum >>> FRAC_SIZE;

  always_comb begin
    w_res = w_rnd[QLEN-1:0];
    w_ovf = 1'b0;
    if (w_rnd > C_MAX) begin
      w_res = {1'b0, {(QLEN - 1){1'b1}}};
      w_ovf = 1'b1;
    end else if (w_rnd < C_MIN) begin
      w_res = {1'b1, {(QLEN - 1){1'b0}}};
      w_ovf = 1'b1;
    end
  end

  // Data registers only load with a live sample, so idle X operands never reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod    <= '0;
      r_vld1    <= 1'b0;
      res       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      r_vld1    <= in_valid;
      out_valid <= r_vld1;
      if (in_valid) r_prod <= w_prod;
      if (r_vld1) begin
        res <= w_res;
        ovf <= w_ovf;
      end
    end
  end

endmodule

// File: tb/tb_fxp_mult.sv
// Self-checking bench for fxp_mult at Q4.12: directed vectors, random stream, reset corners.
module tb_fxp_mult;

  localparam int QLEN = 16;
  localparam int FRAC = 12;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic [QLEN-1:0] a = '0;
  logic [QLEN-1:0] b = '0;
  logic [QLEN-1:0] res;
  logic            out_valid;
  logic            ovf;

  fxp_mult #(.QLEN(QLEN), .FRAC_SIZE(FRAC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .res(res), .out_valid(out_valid), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [QLEN-1:0] res;
    logic            ovf;
    int              cyc;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic [QLEN-1:0] a;
    logic [QLEN-1:0] b;
    logic [QLEN-1:0] res;
    logic            ovf;
  } vec_t;
  vec_t vecs[10];

  int errors = 0;
  int checks = 0;
  int n_in = 0;
  int n_out = 0;

  function automatic void golden(input logic [QLEN-1:0] x, input logic [QLEN-1:0] y,
                                 output logic [QLEN-1:0] r, output logic o);
    longint p;
    longint rr;
    p  = longint'($signed(x)) * longint'($signed(y));
    rr = (p + (longint'(1) << (FRAC - 1))) >>> FRAC;
    if (rr > 32767) begin
      r = 16'h7FFF; o = 1'b1;
    end else if (rr < -32768) begin
      r = 16'h8000; o = 1'b1;
    end else begin
      r = rr[15:0]; o = 1'b0;
    end
  endfunction

  task automatic send(input logic [QLEN-1:0] x, input logic [QLEN-1:0] y,
                      input logic [QLEN-1:0] er, input logic eo);
    exp_t e;
    @(posedge clk); #1;
    in_valid = 1'b1; a = x; b = y;
    e.res = er; e.ovf = eo; e.cyc = cyc + 2;
    q.push_back(e);
    n_in++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0; a = 'x; b = 'x;
    end
  endtask

  task automatic check_zero(input string name);
    @(negedge clk);
    checks++;
    if (res !== '0 || ovf !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s: res=%h ovf=%b out_valid=%b, required 0/0/0", name, res, ovf, out_valid);
    end
  endtask

  // Scoreboard: each out_valid must match the oldest pending sample, at exactly 2 cycles.
  always @(negedge clk) begin
    if (rst_n && out_valid === 1'b1) begin
      exp_t e;
      n_out++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: res=%h ovf=%b with nothing pending", res, ovf);
      end else begin
        e = q.pop_front();
        if (res !== e.res || ovf !== e.ovf || cyc != e.cyc) begin
          errors++;
          $display("FAIL sample: res=%h ovf=%b cyc=%0d, required res=%h ovf=%b cyc=%0d",
                   res, ovf, cyc, e.res, e.ovf, e.cyc);
        end
      end
    end
  end

  initial begin
    logic [QLEN-1:0] x, y, er;
    logic            eo;

    vecs[0] = '{16'h1000, 16'h1000, 16'h1000, 1'b0};
    vecs[1] = '{16'h2000, 16'hE800, 16'hD000, 1'b0};
    vecs[2] = '{16'h8000, 16'h1000, 16'h8000, 1'b0};
    vecs[3] = '{16'h0001, 16'h0800, 16'h0001, 1'b0};
    vecs[4] = '{16'hFFFF, 16'h0800, 16'h0000, 1'b0};
    vecs[5] = '{16'h0001, 16'h07FF, 16'h0000, 1'b0};
    vecs[6] = '{16'h4000, 16'h4000, 16'h7FFF, 1'b1};
    vecs[7] = '{16'h8000, 16'h8000, 16'h7FFF, 1'b1};
    vecs[8] = '{16'h4000, 16'hC000, 16'h8000, 1'b1};
    vecs[9] = '{16'h7FFF, 16'h1000, 16'h7FFF, 1'b0};

    // Held in reset with live random operands: outputs stay zero.
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = QLEN'($urandom); b = QLEN'($urandom);
      check_zero("reset_hold");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_zero("after_release");
    check_zero("after_release");

    // Directed vectors back to back; first one also checks release-to-output latency.
    foreach (vecs[i]) send(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ovf);
    idle(4);

    // Random stream with gaps.
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        x = QLEN'($urandom); y = QLEN'($urandom);
        if ($urandom_range(0, 7) == 0) x = 16'h8000;
        golden(x, y, er, eo);
        send(x, y, er, eo);
      end else begin
        idle(1);
      end
    end
    idle(4);

    // Mid-stream reset: s1 in stage 1, s2 on the inputs when reset hits; neither may appear.
    @(posedge clk); #1;
    in_valid = 1'b1; a = 16'h1000; b = 16'h2000;
    @(posedge clk); #1;
    a = 16'h3000; b = 16'h1000;
    #1 rst_n = 1'b0;
    @(posedge clk); #2;
    in_valid = 1'b0; a = 'x; b = 'x;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) check_zero("midreset_flush");
    send(16'h2000, 16'h2000, 16'h4000, 1'b0);
    idle(4);

    checks++;
    if (n_out != n_in || q.size() != 0) begin
      errors++;
      $display("FAIL count: out_valid count=%0d pending=%0d, required %0d and 0",
               n_out, q.size(), n_in);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
